// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker.
//   state_t      : checker FSM state encoding
//   TT_*         : expected truth tables, bit index {a,b}
//   sat_inc8     : saturating 8-bit increment used by the error counter
package gate_chk_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned VEC_W  = 2;
    localparam int unsigned LOOP_W = 8;
    localparam int unsigned ERR_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc8(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Dwell counter for the DRIVE phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to zero (has priority over en)
//   en         : count up one per cycle
//   expired_c  : combinational flag, count has reached SETTLE-1
module settle_timer
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt;

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = (cnt == LAST);

endmodule

// File: rtl/gate_vector_checker.sv
// Self-running stimulus/response checker for a 2-input gate.
// Walks {a,b} through 00,01,10,11 LOOPS times, dwells SETTLE cycles on each
// vector, samples o for one cycle and scores it against EXP_TT.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : run request, honoured only in IDLE
//   o          : output of the gate under test
//   a, b       : gate inputs, {a,b} = current vector
//   busy       : run in progress
//   done       : one-cycle end-of-run pulse
//   pass       : no mismatches in the last run
//   err_cnt    : saturating mismatch count for the run
//   fail_idx   : {a,b} of the first mismatch of the run
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0]  EXP_TT = 4'b0111,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned LOOPS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       o,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [1:0] fail_idx
);

    localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);
    localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(3);

    state_t            state, state_nxt;
    logic [VEC_W-1:0]  vec, vec_nxt;
    logic [LOOP_W-1:0] loop, loop_nxt;
    logic [ERR_W-1:0]  err_nxt;
    logic [VEC_W-1:0]  fidx_nxt;
    logic              pass_nxt, done_nxt, busy_nxt, a_nxt, b_nxt;
    logic              timer_clr_c, timer_en_c, expired_c, mismatch_c;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (timer_clr_c),
        .en        (timer_en_c),
        .expired_c (expired_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= '0;
            loop     <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            a        <= 1'b0;
            b        <= 1'b0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            loop     <= loop_nxt;
            err_cnt  <= err_nxt;
            fail_idx <= fidx_nxt;
            pass     <= pass_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
            a        <= a_nxt;
            b        <= b_nxt;
        end
    end

    // Next-state, scoreboard and next-output logic
    always_comb begin
        state_nxt   = state;
        vec_nxt     = vec;
        loop_nxt    = loop;
        err_nxt     = err_cnt;
        fidx_nxt    = fail_idx;
        pass_nxt    = pass;
        done_nxt    = 1'b0;
        timer_clr_c = 1'b1;
        timer_en_c  = 1'b0;
        mismatch_c  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    vec_nxt   = '0;
                    loop_nxt  = '0;
                    err_nxt   = '0;
                    fidx_nxt  = '0;
                    pass_nxt  = 1'b0;
                end
            end
            DRIVE: begin
                timer_clr_c = 1'b0;
                timer_en_c  = 1'b1;
                if (expired_c) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                // X/Z on o is scored as a mismatch.
                mismatch_c = (o !== EXP_TT[vec]);
                if (mismatch_c) begin
                    err_nxt = sat_inc8(err_cnt);
                    // err_cnt is cleared at start, so zero means first mismatch.
                    if (err_cnt == '0) begin
                        fidx_nxt = vec;
                    end
                end
                if ((vec == LAST_VEC) && (loop == LAST_LOOP)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    state_nxt = DRIVE;
                    vec_nxt   = vec + VEC_W'(1);
                    if (vec == LAST_VEC) begin
                        loop_nxt = loop + LOOP_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == DRIVE) || (state_nxt == SAMPLE);
        a_nxt    = busy_nxt ? vec_nxt[1] : 1'b0;
        b_nxt    = busy_nxt ? vec_nxt[0] : 1'b0;
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: four checker instances share
// clock and reset, each wrapped around a bench-modelled gate.
//   u0 : defaults, NAND gate
//   u1 : EXP_TT=TT_AND, NAND gate
//   u2 : defaults, stuck-at-1 gate
//   u3 : LOOPS=3 SETTLE=1, NAND gate or stuck-at-0 (sa0)
module tb_gate_vector_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start;
    logic       sa0;
    logic [3:0] a, b, busy, done, pass, ov;
    logic [7:0] err [4];
    logic [1:0] fidx [4];

    int checks = 0;
    int errors = 0;
    logic saw_done;

    always #5 clk = ~clk;

    assign ov[0] = ~(a[0] & b[0]);
    assign ov[1] = ~(a[1] & b[1]);
    assign ov[2] = 1'b1;
    assign ov[3] = sa0 ? 1'b0 : ~(a[3] & b[3]);

    gate_vector_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .o(ov[0]),
        .a(a[0]), .b(b[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(err[0]), .fail_idx(fidx[0])
    );

    gate_vector_checker #(.EXP_TT(TT_AND)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .o(ov[1]),
        .a(a[1]), .b(b[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(err[1]), .fail_idx(fidx[1])
    );

    gate_vector_checker u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .o(ov[2]),
        .a(a[2]), .b(b[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_cnt(err[2]), .fail_idx(fidx[2])
    );

    gate_vector_checker #(.LOOPS(3), .SETTLE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .o(ov[3]),
        .a(a[3]), .b(b[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .err_cnt(err[3]), .fail_idx(fidx[3])
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns 1 unit after the accepting edge.
    task automatic pulse(input int i);
        start[i] = 1'b1;
        step(1);
        start[i] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        sa0   = 1'b0;
        #2;
        chk("rst_ab",    8'({a[0], b[0]}), 8'h0);
        chk("rst_busy",  8'(busy), 8'h0);
        chk("rst_done",  8'(done), 8'h0);
        chk("rst_pass",  8'(pass), 8'h0);
        chk("rst_err",   err[0], 8'h0);
        chk("rst_fidx",  8'(fidx[0]), 8'h0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // NAND, defaults: 3 cycles per vector, done at edge 12
        pulse(0);
        chk("t1_busy_e0", 8'(busy[0]), 8'h1);
        chk("t1_ab_e0",   8'({a[0], b[0]}), 8'h0);
        step(3);
        chk("t1_ab_e3",   8'({a[0], b[0]}), 8'h1);
        step(3);
        chk("t1_ab_e6",   8'({a[0], b[0]}), 8'h2);
        step(3);
        chk("t1_ab_e9",   8'({a[0], b[0]}), 8'h3);
        step(2);
        chk("t1_done_e11", 8'(done[0]), 8'h0);
        chk("t1_busy_e11", 8'(busy[0]), 8'h1);
        step(1);
        chk("t1_done_e12", 8'(done[0]), 8'h1);
        chk("t1_pass",     8'(pass[0]), 8'h1);
        chk("t1_err",      err[0], 8'h0);
        chk("t1_busy_e12", 8'(busy[0]), 8'h0);
        chk("t1_ab_e12",   8'({a[0], b[0]}), 8'h0);
        step(1);
        chk("t1_done_e13", 8'(done[0]), 8'h0);
        chk("t1_pass_hold", 8'(pass[0]), 8'h1);

        // AND table against NAND gate: every vector mismatches
        pulse(1);
        step(3);
        chk("t2_err_e3",  err[1], 8'h1);
        chk("t2_fidx_e3", 8'(fidx[1]), 8'h0);
        step(9);
        chk("t2_done", 8'(done[1]), 8'h1);
        chk("t2_err",  err[1], 8'h4);
        chk("t2_fidx", 8'(fidx[1]), 8'h0);
        chk("t2_pass", 8'(pass[1]), 8'h0);

        // Stuck-at-1 gate: only vector 11 fails
        pulse(2);
        step(12);
        chk("t3_done", 8'(done[2]), 8'h1);
        chk("t3_err",  err[2], 8'h1);
        chk("t3_fidx", 8'(fidx[2]), 8'h3);
        chk("t3_pass", 8'(pass[2]), 8'h0);

        // LOOPS=3 SETTLE=1: done at edge 24
        pulse(3);
        step(23);
        chk("t4_done_e23", 8'(done[3]), 8'h0);
        step(1);
        chk("t4_done_e24", 8'(done[3]), 8'h1);
        chk("t4_pass",     8'(pass[3]), 8'h1);
        chk("t4_err",      err[3], 8'h0);
        step(1);
        sa0 = 1'b1;
        pulse(3);
        chk("t4_pass_clr", 8'(pass[3]), 8'h0);
        step(24);
        chk("t4b_done", 8'(done[3]), 8'h1);
        chk("t4b_err",  err[3], 8'h9);
        chk("t4b_fidx", 8'(fidx[3]), 8'h0);
        chk("t4b_pass", 8'(pass[3]), 8'h0);
        sa0 = 1'b0;
        step(1);

        // Reset during vector 2 SAMPLE
        pulse(0);
        step(8);
        chk("t5_ab_pre", 8'({a[0], b[0]}), 8'h2);
        rst_n = 1'b0;
        #1;
        chk("t5_ab",    8'({a[0], b[0]}), 8'h0);
        chk("t5_busy",  8'(busy[0]), 8'h0);
        chk("t5_err1",  err[1], 8'h0);
        chk("t5_fidx2", 8'(fidx[2]), 8'h0);
        chk("t5_err3",  err[3], 8'h0);
        step(2);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            saw_done = saw_done | done[0];
        end
        chk("t5_no_done", 8'(saw_done), 8'h0);
        chk("t5_idle",    8'(busy[0]), 8'h0);
        pulse(0);
        step(12);
        chk("t5_rerun_done", 8'(done[0]), 8'h1);
        chk("t5_rerun_pass", 8'(pass[0]), 8'h1);
        chk("t5_rerun_err",  err[0], 8'h0);
        step(1);

        // start while busy and in DONE is ignored
        pulse(0);
        step(3);
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(7);
        chk("t6_done_e11", 8'(done[0]), 8'h0);
        chk("t6_busy_e11", 8'(busy[0]), 8'h1);
        step(1);
        chk("t6_done_e12", 8'(done[0]), 8'h1);
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        chk("t6_done_e13", 8'(done[0]), 8'h0);
        chk("t6_busy_e13", 8'(busy[0]), 8'h0);
        step(1);
        chk("t6_busy_e14", 8'(busy[0]), 8'h0);

        // start held high: back-to-back runs with one IDLE cycle between
        start[0] = 1'b1;
        step(1);
        chk("t6h_busy_e0", 8'(busy[0]), 8'h1);
        step(12);
        chk("t6h_done_e12", 8'(done[0]), 8'h1);
        step(1);
        chk("t6h_idle_e13", 8'(busy[0]), 8'h0);
        step(1);
        chk("t6h_busy_e14", 8'(busy[0]), 8'h1);
        step(12);
        chk("t6h_done_e26", 8'(done[0]), 8'h1);
        chk("t6h_pass",     8'(pass[0]), 8'h1);
        start[0] = 1'b0;
        step(2);
        chk("t6h_end_idle", 8'(busy[0]), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
